// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, registers the instruction-memory word
// into the IF/ID slot, and applies stalls, EX redirects, halt and fault.
module instr_fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 64,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] HALT  = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  // Highest PC whose full word still lies inside the populated memory.
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);

  logic [1:0]  state;
  logic [63:0] pc;
  logic        tgt_misaligned;

  assign Inst_Address   = pc;
  assign halted         = (state == HALT);
  assign fault          = (state == FAULT);
  assign tgt_misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_pc       <= 64'h0;
      if_instr    <= NOP_WORD;
      if_valid    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid && tgt_misaligned) begin
            state    <= FAULT;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else if (redirect_valid) begin
            // Redirect beats stall: the bubble replaces the wrong-path word.
            pc       <= redirect_target;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else if (stall) begin
            pc       <= pc;
          end else if (pc > LAST_PC) begin
            state    <= HALT;
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
          end else begin
            if_pc       <= pc;
            if_instr    <= Instruction;
            if_valid    <= 1'b1;
            pc          <= pc + 64'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
          if (redirect_valid && tgt_misaligned) begin
            state <= FAULT;
          end else if (redirect_valid) begin
            state <= RUN;
            pc    <= redirect_target;
          end
        end
        default: begin
          // FAULT is absorbing; only reset leaves it.
          state    <= FAULT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed walk through the fetch
// scenarios followed by randomized stall/redirect/reset traffic vs. a model.
module tb_instr_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] OOR_WORD = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid, halted, fault;
  logic [31:0] fetch_count;

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .Inst_Address(Inst_Address), .Instruction(Instruction),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // 64-byte instruction memory; anything beyond reads as a marker word.
  logic [31:0] mem [16];
  always_comb Instruction = (Inst_Address < 64) ? mem[Inst_Address[5:2]] : OOR_WORD;

  function automatic logic [31:0] mem_at(input logic [63:0] a);
    return (a < 64) ? mem[a[5:2]] : OOR_WORD;
  endfunction

  // Reference model: mode 0 fetching, 1 halted, 2 faulted.
  int          m_mode;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_v;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_mode = 0; m_pc = RESET_PC; m_ifpc = 0; m_instr = NOP; m_v = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (redirect_valid && redirect_target[1:0] != 0) begin
        m_mode = 2; m_v = 0; m_instr = NOP;
      end else if (redirect_valid) begin
        m_pc = redirect_target; m_v = 0; m_instr = NOP;
      end else if (stall) begin
        // everything holds
      end else if (m_pc + 4 > 64) begin
        m_mode = 1; m_v = 0; m_instr = NOP;
      end else begin
        m_ifpc = m_pc; m_instr = mem_at(m_pc); m_v = 1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end else if (m_mode == 1) begin
      if (redirect_valid && redirect_target[1:0] != 0) m_mode = 2;
      else if (redirect_valid) begin m_mode = 0; m_pc = redirect_target; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("addr",   Inst_Address, m_pc);
    chk("if_v",   64'(if_valid), 64'(m_v));
    chk("instr",  64'(if_instr), 64'(m_instr));
    chk("if_pc",  if_pc, m_ifpc);
    chk("count",  64'(fetch_count), 64'(m_cnt));
    chk("halted", 64'(halted), 64'(m_mode == 1));
    chk("fault",  64'(fault), 64'(m_mode == 2));
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [63:0] t);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t;
  endtask

  initial begin
    int guard;
    mem[0] = 32'h1000_0513; mem[1] = 32'h0050_0293;
    mem[2] = 32'h0000_0b13; mem[3] = 32'h0000_0b93;
    for (int i = 4; i < 16; i++) mem[i] = $urandom;
    m_mode = 0; m_pc = 0; m_ifpc = 0; m_instr = NOP; m_v = 0; m_cnt = 0;

    // Reset state
    drive(1, 0, 0, 0);
    step(); step();
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_instr", 64'(if_instr), 64'(NOP));

    // Sequential fetch: 2 edges, then stall 3 cycles at if_pc=4
    drive(0, 0, 0, 0);
    step(); step();
    chk("seq_pc4", if_pc, 64'd4);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", if_pc, 64'd4);
      chk("stall_ins", 64'(if_instr), 64'h0050_0293);
      chk("stall_addr", Inst_Address, 64'd8);
      chk("stall_cnt", 64'(fetch_count), 64'd2);
    end
    drive(0, 0, 0, 0);
    step(); chk("post_stall", if_pc, 64'd8);
    step(); chk("seq_pc12", if_pc, 64'd12);
    chk("seq_ins12", 64'(if_instr), 64'h0000_0b93);
    step(); chk("seq_addr20", Inst_Address, 64'd20);

    // Redirect wins over a simultaneous stall
    drive(0, 1, 1, 64'd8);
    step();
    chk("redir_v", 64'(if_valid), 64'd0);
    chk("redir_nop", 64'(if_instr), 64'(NOP));
    chk("redir_addr", Inst_Address, 64'd8);
    drive(0, 0, 0, 0);
    step(); chk("redir_tgt", if_pc, 64'd8);

    // Run off the end of memory into HALT
    guard = 0;
    while (m_mode != 1 && guard < 40) begin step(); guard++; end
    chk("halt_reached", 64'(halted), 64'd1);
    chk("halt_addr", Inst_Address, 64'd64);
    for (int i = 0; i < 4; i++) begin drive(0, i[0], 0, 0); step(); end
    drive(0, 0, 1, 64'h0c);
    step(); chk("resume_halt", 64'(halted), 64'd0);
    drive(0, 0, 0, 0);
    step(); chk("resume_pc", if_pc, 64'h0c);

    // Misaligned redirect -> sticky fault
    drive(0, 0, 1, 64'h1a);
    step(); chk("fault_set", 64'(fault), 64'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 64'($urandom_range(0, 15)) << 2);
      step();
    end
    chk("fault_sticky", 64'(fault), 64'd1);
    drive(1, 0, 0, 0);
    step(); chk("fault_clr", 64'(fault), 64'd0);
    chk("fault_rstpc", Inst_Address, RESET_PC);

    // Reset mid-stall / mid-redirect at pc=0x18
    drive(0, 0, 0, 0);
    guard = 0;
    while (m_pc != 64'h18 && guard < 20) begin step(); guard++; end
    chk("reach_18", Inst_Address, 64'h18);
    drive(1, 1, 1, 64'h30);
    step();
    chk("mid_rst_cnt", 64'(fetch_count), 64'd0);
    chk("mid_rst_pc", Inst_Address, RESET_PC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic rv;
      logic [63:0] t;
      rv = ($urandom_range(0, 19) == 0);
      t  = 64'($urandom_range(0, 20)) << 2;
      if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, rv, t);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch-stage sequencer for the pipelined RISC-V core.
- Owns the program counter (PC) and drives the address into the combinational Instruction_Memory.
- Registers the returned word into the IF/ID slot.
- Applies hazard-unit stalls and execute-stage branch/jump redirects.
- Stops fetching once the PC leaves the populated instruction-memory window.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 64, byte size of the instruction memory. A fetch at PC > IMEM_BYTES-4 halts the fetch unit.
- NOP_WORD, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch or jump from EX; flushes IF/ID.
- redirect_target  in  64  new PC when redirect_valid=1.
- Inst_Address  out  64  byte address to Instruction_Memory. Combinational, equal to the internal PC.
- Instruction  in  32  word returned combinationally by Instruction_Memory for Inst_Address.
- if_pc  out  64  registered PC of the instruction in the IF/ID slot.
- if_instr  out  32  registered instruction in the IF/ID slot.
- if_valid  out  1  IF/ID slot holds a real instruction.
- halted  out  1  fetch unit is in HALT.
- fault  out  1  sticky misaligned-redirect error.
- fetch_count  out  32  number of instructions delivered with if_valid=1.

Behaviour:
- Reset (reset=1 at a rising edge, in any state, including mid-stall or mid-redirect):
  - pc <= RESET_PC, state <= RUN.
  - if_pc <= 0, if_instr <= NOP_WORD, if_valid <= 0.
  - halted <= 0, fault <= 0, fetch_count <= 0.
  - First real fetch occurs at the first edge with reset=0; if_valid rises one cycle after reset deasserts.
- Inst_Address = pc at all times, including in HALT and FAULT.
- States are RUN, HALT and FAULT. halted=1 only in HALT; fault=1 only in FAULT.
- RUN: evaluated each edge in this priority order:
  1. redirect_valid=1 and redirect_target[1:0]!=0:
     - state <= FAULT, if_valid <= 0, if_instr <= NOP_WORD; pc unchanged.
  2. redirect_valid=1, aligned target:
     - pc <= redirect_target, if_valid <= 0, if_instr <= NOP_WORD; if_pc unchanged.
     - Redirect wins over a simultaneous stall.
  3. stall=1: pc, if_pc, if_instr and if_valid all hold.
  4. pc > IMEM_BYTES-4 (out of window):
     - state <= HALT, if_valid <= 0, if_instr <= NOP_WORD; pc holds.
  5. Otherwise (normal fetch):
     - if_pc <= pc, if_instr <= Instruction, if_valid <= 1.
     - pc <= pc+4 (64-bit, wraps modulo 2^64).
     - fetch_count <= fetch_count+1 (wraps at 2^32).
- Fetch latency: the word at address A appears on if_instr one edge after pc=A, with no stall or redirect on that edge. Throughput is 1 instruction/cycle.
- Redirect penalty:
  - The edge carrying the redirect produces one bubble.
  - The target instruction is valid on the following edge.
  - If stall is asserted on the edge after the redirect, the bubble holds.
- HALT:
  - if_valid stays 0; stall is ignored.
  - An aligned redirect_valid sets pc <= target and state <= RUN.
  - A misaligned redirect goes to FAULT.
  - Fetching resumes on the next edge.
- FAULT:
  - Absorbing until reset. All inputs are ignored.
  - if_valid=0, outputs hold, pc holds.
- fetch_count increments only on edges where if_valid is newly loaded with 1. It never changes on stall, bubble, halt or fault.
- if_pc / if_instr are meaningful only when if_valid=1. if_instr is always NOP_WORD when if_valid=0, except during a stall, when it holds its prior value.

Test Plan:
1. Sequential fetch:
   - Memory loaded with words 0x10000513, 0x00500293, 0x00000b13, 0x00000b93 at 0,4,8,12. Release reset, no stall.
   - Edges 1–4: if_pc=0,4,8,12, if_instr matches those words, if_valid=1, fetch_count=1..4.
2. Stall hold:
   - stall=1 for 3 cycles while if_pc=4.
   - if_pc=4, if_instr=0x00500293 and Inst_Address=8 for all 3 cycles; fetch_count frozen at 2.
   - After release, the next edge gives if_pc=8.
3. Redirect over stall:
   - At pc=20, assert redirect_valid=1 with target=8 and stall=1 on the same edge.
   - Next edge: if_valid=0, if_instr=0x00000013, Inst_Address=8.
   - Following edge: if_pc=8, if_valid=1.
4. Halt and resume (IMEM_BYTES=64):
   - Run to pc=64: halted=1, if_valid=0, Inst_Address holds 64, stall toggling has no effect.
   - Redirect to 0x0C: halted=0, next valid if_pc=0x0C.
5. Misaligned redirect:
   - redirect_target=0x1A: fault=1, if_valid=0; later redirects and stalls are ignored.
   - reset=1 clears fault and restores pc=RESET_PC.
6. Reset mid-operation:
   - Assert reset while stall=1 and redirect_valid=1 at pc=0x18.
   - Next edge: pc=RESET_PC, if_valid=0, fetch_count=0, state RUN.
